// File: rtl/pattern3_checker.sv
// Receive-side checker for the 3-bit binary count pattern on {in0,in1,in2}: acquires lock, then counts mismatches and wraps.
// Optional PATTERN3_CHECK_STICKY_EN adds a sticky_err output latched on any counted error.
module pattern3_checker #(
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             in0,
  input  logic             in1,
  input  logic             in2,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             all_ones,
  output logic [1:0]       state
`ifdef PATTERN3_CHECK_STICKY_EN
  ,
  output logic             sticky_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HUNT = 2'b01,
    ST_LOCK = 2'b10
  } state_e;

  localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_ERR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             all_ones_q, all_ones_d;
  logic             locked_q, locked_d;
  logic             err_hit, wrap_hit;
  logic [2:0]       val;

  assign val = {in0, in1, in2};

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    good_d     = good_q;
    bad_d      = bad_q;
    all_ones_d = all_ones_q;
    err_hit    = 1'b0;
    wrap_hit   = 1'b0;
    if (sample_en) begin
      all_ones_d = &val;
      unique case (state_q)
        ST_IDLE: begin
          exp_d   = val + 3'd1;
          good_d  = 4'd1;
          state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (val == exp_q) begin
            exp_d  = exp_q + 3'd1;
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_N) begin
              state_d = ST_LOCK;
              bad_d   = '0;
            end
          end else begin
            exp_d  = val + 3'd1;
            good_d = 4'd1;
          end
        end
        ST_LOCK: begin
          // Expected value free-runs through errors so one bad sample costs one error.
          exp_d = exp_q + 3'd1;
          if (val == exp_q) begin
            bad_d    = '0;
            wrap_hit = (val == 3'd0);
          end else begin
            err_hit = 1'b1;
            bad_d   = bad_q + 4'd1;
            if (bad_q + 4'd1 == UNLOCK_N) begin
              state_d = ST_HUNT;
              exp_d   = val + 3'd1;
              good_d  = 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    err_pulse_d = err_hit;
    locked_d    = (state_d == ST_LOCK);

    if (clr)                                      err_cnt_d = '0;
    else if (err_hit && (err_cnt_q != CNT_MAX))   err_cnt_d = err_cnt_q + 1'b1;
    else                                          err_cnt_d = err_cnt_q;

    if (clr)                                      wrap_cnt_d = '0;
    else if (wrap_hit && (wrap_cnt_q != CNT_MAX)) wrap_cnt_d = wrap_cnt_q + 1'b1;
    else                                          wrap_cnt_d = wrap_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      exp_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      all_ones_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      err_pulse_q <= err_pulse_d;
      all_ones_q  <= all_ones_d;
      locked_q    <= locked_d;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign all_ones  = all_ones_q;

`ifdef PATTERN3_CHECK_STICKY_EN
  logic sticky_q, sticky_d;

  // A new error wins over a coincident clear.
  always_comb begin
    sticky_d = sticky_q;
    if (err_hit)  sticky_d = 1'b1;
    else if (clr) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_err = sticky_q;
`endif

endmodule

// File: tb/tb_pattern3_checker.sv
// Scoreboard bench for pattern3_checker: stimulus pushes model predictions, a monitor pops and compares after each edge.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_pattern3_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_ERR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       in0 = 1'b0, in1 = 1'b0, in2 = 1'b0;
  logic       clr = 1'b0;
  logic       locked, err_pulse, all_ones;
  logic [7:0] err_cnt, wrap_cnt;
  logic [1:0] state;
  logic       locked2, err_pulse2, all_ones2;
  logic [1:0] err_cnt2, wrap_cnt2;
  logic [1:0] state2;
`ifdef PATTERN3_CHECK_STICKY_EN
  logic       sticky_err, sticky_err2;
`endif

  pattern3_checker #(.CNT_W(8), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .in0(in0), .in1(in1), .in2(in2), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
    .all_ones(all_ones), .state(state)
`ifdef PATTERN3_CHECK_STICKY_EN
    , .sticky_err(sticky_err)
`endif
  );

  pattern3_checker #(.CNT_W(2), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR)) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en),
    .in0(in0), .in1(in1), .in2(in2), .clr(clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2),
    .all_ones(all_ones2), .state(state2)
`ifdef PATTERN3_CHECK_STICKY_EN
    , .sticky_err(sticky_err2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int lk; int ep; int ec; int wc; int ec2; int wc2; int ao; int sk;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: mode 0=idle, 1=hunting, 2=locked; raw counts are unsaturated.
  int m_mode, m_exp, m_good, m_bad, m_err, m_wrap, m_ao, m_sticky;
  int gen;

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0;
    m_err = 0; m_wrap = 0; m_ao = 0; m_sticky = 0;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input bit en, input int v, input bit c);
    bit   hit_err, hit_wrap;
    exp_t e;
    hit_err  = 1'b0;
    hit_wrap = 1'b0;
    if (en) begin
      m_ao = (v == 7) ? 1 : 0;
      if (m_mode == 0) begin
        m_exp = (v + 1) % 8; m_good = 1; m_mode = 1;
      end else if (m_mode == 1) begin
        if (v == m_exp) begin
          m_exp = (m_exp + 1) % 8;
          m_good++;
          if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
        end else begin
          m_exp = (v + 1) % 8; m_good = 1;
        end
      end else begin
        if (v == m_exp) begin
          m_bad = 0;
          hit_wrap = (v == 0);
        end else begin
          hit_err = 1'b1;
          m_bad++;
        end
        m_exp = (m_exp + 1) % 8;
        if (m_bad == UNLOCK_ERR) begin
          m_mode = 1; m_exp = (v + 1) % 8; m_good = 1;
        end
      end
    end
    if (c) begin m_err = 0; m_wrap = 0; end
    else begin
      if (hit_err)  m_err++;
      if (hit_wrap) m_wrap++;
    end
    if (hit_err) m_sticky = 1;
    else if (c)  m_sticky = 0;
    e.st  = m_mode;
    e.lk  = (m_mode == 2) ? 1 : 0;
    e.ep  = hit_err ? 1 : 0;
    e.ec  = sat(m_err, 255);
    e.wc  = sat(m_wrap, 255);
    e.ec2 = sat(m_err, 3);
    e.wc2 = sat(m_wrap, 3);
    e.ao  = m_ao;
    e.sk  = m_sticky;
    sbq.push_back(e);
  endtask

  task automatic send(input bit en, input int v, input bit c);
    @(negedge clk);
    sample_en = en;
    {in0, in1, in2} = 3'(v);
    clr = c;
    model_step(en, v, c);
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      send(1'b1, gen, 1'b0);
      gen = (gen + 1) % 8;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err_pulse"}, int'(err_pulse), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_wrap_cnt"}, int'(wrap_cnt), 0);
    chk({tag, "_all_ones"}, int'(all_ones), 0);
    chk({tag, "_err_cnt2"}, int'(err_cnt2), 0);
    chk({tag, "_state2"}, int'(state2), 0);
`ifdef PATTERN3_CHECK_STICKY_EN
    chk({tag, "_sticky"}, int'(sticky_err), 0);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("state", int'(state), mon_e.st);
        chk("locked", int'(locked), mon_e.lk);
        chk("err_pulse", int'(err_pulse), mon_e.ep);
        chk("err_cnt", int'(err_cnt), mon_e.ec);
        chk("wrap_cnt", int'(wrap_cnt), mon_e.wc);
        chk("all_ones", int'(all_ones), mon_e.ao);
        chk("err_cnt_w2", int'(err_cnt2), mon_e.ec2);
        chk("wrap_cnt_w2", int'(wrap_cnt2), mon_e.wc2);
        chk("err_pulse_w2", int'(err_pulse2), mon_e.ep);
`ifdef PATTERN3_CHECK_STICKY_EN
        chk("sticky_err", int'(sticky_err), mon_e.sk);
        chk("sticky_err_w2", int'(sticky_err2), mon_e.sk);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  v;
    bit  en, c;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean stream from 000: lock on the 4th sample, then 20 more.
    gen = 0;
    send_clean(24);

    // Single corrupted sample in lock: expect 101, drive 111.
    while (gen != 5) send_clean(1);
    send(1'b1, 7, 1'b0);
    gen = 6;
    send_clean(3);

    // Two consecutive wrong samples drop lock, then relock on a clean stream.
    for (int i = 0; i < 2; i++) begin
      send(1'b1, (gen + 3) % 8, 1'b0);
      gen = (gen + 1) % 8;
    end
    send_clean(8);

    // sample_en alternating, stream advances only on enabled cycles.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) send_clean(1);
      else send(1'b0, int'($urandom_range(7, 0)), 1'b0);
    end

    // Repeated single errors in lock to saturate the narrow instance, then clr with an error.
    send_clean(6);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, (gen + 4) % 8, 1'b0);
      gen = (gen + 1) % 8;
      send_clean(2);
    end
    send(1'b1, (gen + 4) % 8, 1'b1);
    gen = (gen + 1) % 8;
    send_clean(3);

    // Randomised traffic: gaps, occasional corruption and clears.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(3, 0) != 0);
      c  = 1'b0;
      v  = int'($urandom_range(7, 0));
      if (en) begin
        if ($urandom_range(15, 0) != 0) v = gen;
        c = ($urandom_range(31, 0) == 0);
        gen = (gen + 1) % 8;
      end
      send(en, v, c);
    end

    // Asynchronous reset between edges while locked.
    send_clean(8);
    @(posedge clk);
    #3;
    chk("pre_reset_locked", int'(locked), 1);
    rst_n = 1'b0;
    sample_en = 1'b0;
    clr = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gen = 3;
    send_clean(12);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
